// File: rtl/spi_stream_rx.sv
// spi_stream_rx: SPI slave (mode 0, LSB first) receiving greyscale bytes and
// emitting a 24-bit {g,g,g} Avalon-ST video stream with sop/eop framing.
// Ports: clk/reset (sync, active high); spi_clk/spi_ss/spi_mosi/spi_miso from
// the external master; source_* Avalon-ST output; overflow/short_frame sticky.
module spi_stream_rx #(
  parameter logic [10:0] IMAGE_W    = 11'd320,
  parameter logic [10:0] IMAGE_H    = 11'd240,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  output logic        overflow,
  output logic        short_frame
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          FRAME    = int'(IMAGE_W) * int'(IMAGE_H);
  localparam logic [16:0] LAST_PIX = 17'(FRAME - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // [1] is the synchronised level, [2] its previous value for edges.
  // Reset to 0 so a slave select already low at reset release shows no
  // falling edge and the block waits for the next frame.
  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      ss_q   <= {ss_q[1:0], spi_ss};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;
  logic mosi_s;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign mosi_s    = mosi_q[1];

  logic       armed;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] byte_reg;
  logic       byte_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      byte_reg  <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss_fall) begin
        armed   <= 1'b1;
        bit_cnt <= '0;
      end else if (ss_rise) begin
        // any partial byte is simply forgotten
        armed   <= 1'b0;
        bit_cnt <= '0;
      end else if (armed && sclk_rise) begin
        shift_reg <= {mosi_s, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          byte_reg  <= {mosi_s, shift_reg[7:1]};
        end
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [16:0]   pix_cnt;
  logic [9:0]    head;
  logic          full;
  logic          pop;
  logic          push;

  assign full         = (count == FULL_CNT);
  assign source_valid = (count != '0);
  assign pop          = source_valid & source_ready;
  assign push         = byte_done & (~full | pop);
  assign head         = mem[rd_ptr];

  assign source_data = source_valid ? {3{head[9:2]}} : 24'd0;
  assign source_sop  = source_valid & head[1];
  assign source_eop  = source_valid & head[0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {byte_reg, pix_cnt == '0, pix_cnt == LAST_PIX};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pix_cnt     <= '0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (byte_done && !push) overflow <= 1'b1;
      // dropped bytes still advance pix_cnt to keep framing aligned
      if (ss_fall) begin
        pix_cnt <= '0;
      end else if (ss_rise && pix_cnt != '0) begin
        short_frame <= 1'b1;
        pix_cnt     <= '0;
      end else if (byte_done) begin
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 17'd1;
      end
    end
  end

  // Status goes out LSB first. bit_cnt is already 0 on the falling edge that
  // ends a byte, which is where the next status byte is reloaded.
  logic [7:0] miso_sr;
  logic [7:0] status;

  assign status   = {6'b0, short_frame, overflow};
  assign spi_miso = miso_sr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_sr <= '0;
    end else if (ss_fall) begin
      miso_sr <= status;
    end else if (armed && sclk_fall) begin
      if (bit_cnt == 3'd0) miso_sr <= status;
      else                 miso_sr <= {1'b0, miso_sr[7:1]};
    end
  end

endmodule

// File: tb/tb_spi_stream_rx.sv
// tb_spi_stream_rx: directed bench for spi_stream_rx (W=2, H=2, FIFO_DEPTH=4).
// Drives SPI as master at clk/4 and checks stream, framing, flags and MISO.
module tb_spi_stream_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic        overflow;
  logic        short_frame;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [23:0] d;
    logic        s;
    logic        e;
  } item_t;

  item_t q[$];

  spi_stream_rx #(
    .IMAGE_W(11'd2),
    .IMAGE_H(11'd2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_clk(spi_clk),
    .spi_ss(spi_ss),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .source_data(source_data),
    .source_valid(source_valid),
    .source_ready(source_ready),
    .source_sop(source_sop),
    .source_eop(source_eop),
    .overflow(overflow),
    .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #1;
    if (source_valid && source_ready)
      q.push_back({source_data, source_sop, source_eop});
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic ss_start();
    spi_ss = 1'b1;
    tick(4);
    spi_ss = 1'b0;
    tick(4);
  endtask

  task automatic ss_end();
    tick(2);
    spi_ss = 1'b1;
    tick(6);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n,
                           output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[i];
      tick(2);
      spi_clk = 1'b1;
      tick(2);
      mi[i] = spi_miso;
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] mi;
    send_bits(b, 8, mi);
  endtask

  task automatic expect_item(input string tag, input logic [7:0] d,
                             input logic s, input logic e);
    item_t it;
    int k = 0;
    while (q.size() == 0 && k < 100) begin
      tick(1);
      k++;
    end
    check({tag, "_avail"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      it = q.pop_front();
      check({tag, "_data"}, 32'(it.d), 32'({3{d}}));
      check({tag, "_sop"}, 32'(it.s), 32'(s));
      check({tag, "_eop"}, 32'(it.e), 32'(e));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(source_valid), 32'd0);
    check({tag, "_data"}, 32'(source_data), 32'd0);
    check({tag, "_sop"}, 32'(source_sop), 32'd0);
    check({tag, "_eop"}, 32'(source_eop), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_short"}, 32'(short_frame), 32'd0);
    check({tag, "_miso"}, 32'(spi_miso), 32'd0);
  endtask

  logic [7:0] mi;

  initial begin
    reset        = 1'b1;
    spi_clk      = 1'b0;
    spi_ss       = 1'b1;
    spi_mosi     = 1'b0;
    source_ready = 1'b1;
    tick(3);
    check_idle("rst");
    reset = 1'b0;
    tick(2);

    // 1: four-pixel frame, ready high
    ss_start();
    send_bits(8'h00, 8, mi);
    check("t1_miso", 32'(mi), 32'h00);
    send_byte(8'h7F);
    send_byte(8'h80);
    send_byte(8'hFF);
    ss_end();
    expect_item("t1_p0", 8'h00, 1'b1, 1'b0);
    expect_item("t1_p1", 8'h7F, 1'b0, 1'b0);
    expect_item("t1_p2", 8'h80, 1'b0, 1'b0);
    expect_item("t1_p3", 8'hFF, 1'b0, 1'b1);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_short", 32'(short_frame), 32'd0);

    // 2: latency of a single byte
    ss_start();
    send_byte(8'hA5);
    tick(1);
    check("t2_valid_early", 32'(source_valid), 32'd0);
    tick(1);
    check("t2_valid", 32'(source_valid), 32'd1);
    check("t2_data", 32'(source_data), 32'hA5A5A5);
    expect_item("t2_p0", 8'hA5, 1'b1, 1'b0);
    ss_end();
    check("t2_short", 32'(short_frame), 32'd1);
    do_reset();

    // 3: overflow with ready low
    source_ready = 1'b0;
    ss_start();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    tick(6);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_hold_d0", 32'(source_data), 32'h111111);
    check("t3_hold_s0", 32'(source_sop), 32'd1);
    tick(5);
    check("t3_hold_v1", 32'(source_valid), 32'd1);
    check("t3_hold_d1", 32'(source_data), 32'h111111);
    source_ready = 1'b1;
    expect_item("t3_p0", 8'h11, 1'b1, 1'b0);
    expect_item("t3_p1", 8'h22, 1'b0, 1'b0);
    expect_item("t3_p2", 8'h33, 1'b0, 1'b0);
    expect_item("t3_p3", 8'h44, 1'b0, 1'b1);
    tick(5);
    check("t3_dropped", 32'(q.size()), 32'd0);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    expect_item("t3_n1", 8'h66, 1'b0, 1'b0);
    expect_item("t3_n2", 8'h77, 1'b0, 1'b0);
    expect_item("t3_n3", 8'h88, 1'b0, 1'b1);
    expect_item("t3_n0", 8'h99, 1'b1, 1'b0);
    do_reset();

    // 4: partial byte discarded on ss rise
    ss_start();
    send_bits(8'hFF, 3, mi);
    ss_end();
    check("t4_no_partial", 32'(source_valid), 32'd0);
    check("t4_q", 32'(q.size()), 32'd0);
    ss_start();
    send_byte(8'h3C);
    expect_item("t4_p0", 8'h3C, 1'b1, 1'b0);
    check("t4_short", 32'(short_frame), 32'd0);
    do_reset();

    // 5: short frame and status readback
    ss_start();
    send_byte(8'h01);
    send_byte(8'h02);
    tick(4);
    check("t5_short_pre", 32'(short_frame), 32'd0);
    ss_end();
    check("t5_short", 32'(short_frame), 32'd1);
    expect_item("t5_p0", 8'h01, 1'b1, 1'b0);
    expect_item("t5_p1", 8'h02, 1'b0, 1'b0);
    ss_start();
    send_bits(8'hC3, 8, mi);
    check("t5_miso", 32'(mi), 32'h02);
    expect_item("t5_n0", 8'hC3, 1'b1, 1'b0);

    // 6: reset mid-byte with ss low
    ss_start();
    send_bits(8'hF0, 3, mi);
    reset = 1'b1;
    tick(2);
    check_idle("t6_rst");
    reset = 1'b0;
    tick(2);
    send_byte(8'h77);
    tick(8);
    check("t6_ignored_v", 32'(source_valid), 32'd0);
    check("t6_ignored_q", 32'(q.size()), 32'd0);
    ss_end();
    ss_start();
    send_byte(8'h5A);
    expect_item("t6_p0", 8'h5A, 1'b1, 1'b0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_short", 32'(short_frame), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
